// File: rtl/lsq_mem_responder.sv
// rtl/lsq_mem_responder.sv - in-order LSQ memory responder with fixed-latency word RAM (optional RESP_BACKPRESSURE_EN)
module lsq_mem_responder #(
  parameter int DEPTH     = 4,
  parameter int MEM_WORDS = 256,
  parameter int MEM_LAT   = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_pc,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_store,
`ifdef RESP_BACKPRESSURE_EN
  input  logic        resp_ready,
`endif
  output logic        resp_valid,
  output logic [31:0] resp_pc,
  output logic [31:0] resp_data,
  output logic        resp_store,
  output logic        resp_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int IW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);
  localparam logic [CW-1:0] LAT_INIT = CW'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // request FIFO storage
  logic [31:0] fifo_pc_q    [DEPTH];
  logic [31:0] fifo_addr_q  [DEPTH];
  logic [31:0] fifo_wdata_q [DEPTH];
  logic        fifo_store_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;

  // op currently being serviced
  logic [31:0] op_pc_q, op_addr_q, op_wdata_q;
  logic        op_store_q;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pop, access, push;

  logic [31:0] mem_q [MEM_WORDS];

  logic [31:0] resp_pc_q, resp_data_q;
  logic        resp_store_q, resp_err_q;

  logic [IW-1:0] acc_idx;
  logic          acc_err;

  assign req_ready = (count_q != FULL_CNT);
  assign push      = req_valid && req_ready;

  assign acc_idx = op_addr_q[IW+1:2];
  assign acc_err = (op_addr_q[1:0] != 2'b00) || (op_addr_q[31:IW+2] != '0);

  // FIFO payload write; no reset needed since count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]    <= req_pc;
      fifo_addr_q[wr_ptr_q]  <= req_addr;
      fifo_wdata_q[wr_ptr_q] <= req_wdata;
      fifo_store_q[wr_ptr_q] <= req_store;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FSM state and latency counter registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state: pop in IDLE, count down in BUSY, present result in RESP
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    access  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          cnt_d   = LAT_INIT;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          access  = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
`ifdef RESP_BACKPRESSURE_EN
        if (resp_ready) state_d = ST_IDLE;
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // latch the popped head into the op register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      op_pc_q    <= '0;
      op_addr_q  <= '0;
      op_wdata_q <= '0;
      op_store_q <= 1'b0;
    end else if (pop) begin
      op_pc_q    <= fifo_pc_q[rd_ptr_q];
      op_addr_q  <= fifo_addr_q[rd_ptr_q];
      op_wdata_q <= fifo_wdata_q[rd_ptr_q];
      op_store_q <= fifo_store_q[rd_ptr_q];
    end
  end

  // data RAM: cleared on reset, written only by a non-errored store at BUSY->RESP
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
    end else if (access && op_store_q && !acc_err) begin
      mem_q[acc_idx] <= op_wdata_q;
    end
  end

  // completion registers, loaded once per op and held until the next access
  always_ff @(posedge clk) begin
    if (!rstn) begin
      resp_pc_q    <= '0;
      resp_data_q  <= '0;
      resp_store_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else if (access) begin
      resp_pc_q    <= op_pc_q;
      resp_store_q <= op_store_q;
      resp_err_q   <= acc_err;
      resp_data_q  <= (op_store_q || acc_err) ? 32'h0 : mem_q[acc_idx];
    end
  end

  assign resp_valid = (state_q == ST_RESP);
  assign resp_pc    = resp_pc_q;
  assign resp_data  = resp_data_q;
  assign resp_store = resp_store_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsq_mem_responder.sv
// tb/tb_lsq_mem_responder.sv - scoreboard bench for lsq_mem_responder
module tb_lsq_mem_responder;
  localparam int DEPTH     = 4;
  localparam int MEM_WORDS = 256;
  localparam int MEM_LAT   = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_pc = '0, req_addr = '0, req_wdata = '0;
  logic        req_store = 1'b0;
  logic        resp_ready = 1'b1;
  logic        resp_valid;
  logic [31:0] resp_pc, resp_data;
  logic        resp_store, resp_err;

  always #5 clk = ~clk;

  lsq_mem_responder #(.DEPTH(DEPTH), .MEM_WORDS(MEM_WORDS), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_pc(req_pc), .req_addr(req_addr), .req_wdata(req_wdata), .req_store(req_store),
`ifdef RESP_BACKPRESSURE_EN
    .resp_ready(resp_ready),
`endif
    .resp_valid(resp_valid), .resp_pc(resp_pc), .resp_data(resp_data),
    .resp_store(resp_store), .resp_err(resp_err)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        store;
    logic        err;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] ref_mem [MEM_WORDS];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          accept_cyc = 0;
  int          resp_cycles[$];
  int          resp_total = 0;
  int          stall_seen = 0;
  bit          saw_ready_low = 0;
  bit          rand_bp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic model_clear();
    expq.delete();
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = '0;
  endtask

  // reference: word-addressed memory updated strictly in issue order
  task automatic model_accept(input logic [31:0] pc, addr, wdata, input logic st);
    exp_t e;
    int   idx;
    bit   err;
    idx = int'((addr >> 2) % MEM_WORDS);
    err = (addr % 4 != 0) || (addr >= 4 * MEM_WORDS);
    e.pc = pc;
    e.store = st;
    e.err = err;
    e.data = (st || err) ? 32'h0 : ref_mem[idx];
    if (st && !err) ref_mem[idx] = wdata;
    expq.push_back(e);
  endtask

  task automatic issue(input logic [31:0] pc, addr, wdata, input logic st);
    int guard;
    guard = 0;
    @(negedge clk);
    req_valid = 1'b1; req_pc = pc; req_addr = addr; req_wdata = wdata; req_store = st;
    forever begin
      checks++;
      if (!req_ready && expq.size() < DEPTH) begin
        errors++;
        $display("FAIL ready_low_early actual=%0d outstanding required>=%0d", expq.size(), DEPTH);
      end else if (req_ready && expq.size() > DEPTH) begin
        errors++;
        $display("FAIL ready_high_full actual=%0d outstanding required<=%0d", expq.size(), DEPTH);
      end
      if (!req_ready) saw_ready_low = 1;
      if (req_ready || guard >= 300) break;
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      errors++;
      $display("FAIL push_timeout actual=ready0 required=ready1");
    end else begin
      model_accept(pc, addr, wdata, st);
      accept_cyc = cyc;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (expq.size() != 0 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d pending required=0", expq.size());
      expq.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  // monitor: compare each accepted completion, check holding and single-cycle drop
  bit          stall_prev = 0;
  bit          prev_hs = 0;
  logic [31:0] held_pc = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      stall_prev = 0;
      prev_hs = 0;
    end else begin
      if (prev_hs) check("valid_drop_after_accept", {31'b0, resp_valid}, 32'h0);
      if (resp_valid) begin
        if (stall_prev) check("held_pc", resp_pc, held_pc);
        if (!resp_ready) begin
          stall_prev = 1;
          held_pc = resp_pc;
          stall_seen++;
          prev_hs = 0;
        end else begin
          stall_prev = 0;
          prev_hs = 1;
          resp_total++;
          resp_cycles.push_back(cyc);
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp actual_pc=%h required=none", resp_pc);
          end else begin
            e = expq.pop_front();
            check("resp_pc", resp_pc, e.pc);
            check("resp_data", resp_data, e.data);
            check("resp_store", {31'b0, resp_store}, {31'b0, e.store});
            check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
          end
        end
      end else begin
        if (stall_prev) begin
          checks++;
          errors++;
          $display("FAIL dropped_while_stalled actual=0 required=1");
        end
        stall_prev = 0;
        prev_hs = 0;
      end
    end
  end

  // random consumer backpressure during the random phase
  always @(posedge clk) begin
`ifdef RESP_BACKPRESSURE_EN
    if (rand_bp) #1 resp_ready = ($urandom_range(0, 2) != 0);
`endif
  end

  initial begin
    int base;
    int n;
    model_clear();
    do_reset();

    // reset state
    @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check("rst_resp_pc", resp_pc, 32'h0);
    check("rst_resp_data", resp_data, 32'h0);
    check("rst_resp_store", {31'b0, resp_store}, 32'h0);
    check("rst_resp_err", {31'b0, resp_err}, 32'h0);

    // single load latency
    resp_cycles.delete();
    issue(32'h100, 32'h10, 32'h0, 1'b0);
    base = accept_cyc;
    drain();
    checks++;
    if (resp_cycles.size() != 1 || resp_cycles[0] - base != MEM_LAT + 2) begin
      errors++;
      $display("FAIL latency actual=%0d required=%0d",
               resp_cycles.size() ? resp_cycles[0] - base : -1, MEM_LAT + 2);
    end

    // store then load same word
    issue(32'h4, 32'h20, 32'hDEADBEEF, 1'b1);
    issue(32'h8, 32'h20, 32'h0, 1'b0);
    drain();

    // burst beyond FIFO capacity, then throughput between completions
    resp_cycles.delete();
    saw_ready_low = 0;
    for (int i = 0; i < DEPTH + 2; i++)
      issue(32'h200 + 32'(i * 4), 32'h40 + 32'(i * 4), 32'hA000 + 32'(i), 1'(i % 2));
    drain();
    check("burst_ready_low", {31'b0, saw_ready_low}, 32'h1);
    for (int i = 1; i < resp_cycles.size(); i++)
      check("throughput", 32'(resp_cycles[i] - resp_cycles[i-1]), 32'(MEM_LAT + 2));

    // error cases; errored store must not touch RAM
    issue(32'h300, 32'h22, 32'h0, 1'b0);
    issue(32'h304, 32'h400, 32'h0, 1'b0);
    issue(32'h308, 32'h401, 32'h12345678, 1'b1);
    issue(32'h30C, 32'h0, 32'h0, 1'b0);
    issue(32'h310, 32'h20, 32'h0, 1'b0);
    issue(32'h314, 32'h3FC, 32'hCAFEF00D, 1'b1);
    issue(32'h318, 32'h3FC, 32'h0, 1'b0);
    drain();

    // reset while a store is in BUSY
    issue(32'h400, 32'h30, 32'h55, 1'b1);
    @(posedge clk);
    n = resp_total;
    do_reset();
    repeat (10) @(negedge clk);
    check("no_resp_after_reset", 32'(resp_total), 32'(n));
    issue(32'h404, 32'h30, 32'h0, 1'b0);
    drain();

`ifdef RESP_BACKPRESSURE_EN
    // consumer stalls three cycles; queued op must survive
    #1 resp_ready = 1'b0;
    stall_seen = 0;
    issue(32'h600, 32'h20, 32'h0, 1'b0);
    issue(32'h604, 32'h24, 32'h0, 1'b0);
    n = 0;
    while (!resp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 resp_ready = 1'b1;
    drain();
    check("stall_cycles", 32'(stall_seen), 32'h3);
`endif

    // randomized traffic against the reference model
    rand_bp = 1;
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      int r;
      r = $urandom_range(0, 9);
      a = 32'($urandom_range(0, 15)) * 4;
      if (r == 0) a = a + 32'($urandom_range(1, 3));
      if (r == 1) a = a | (32'h400 << $urandom_range(0, 21));
      if (r == 2) a = 32'($urandom_range(0, MEM_WORDS - 1)) * 4;
      issue(32'h1000 + 32'(i * 4), a, $urandom, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    rand_bp = 0;
    #2 resp_ready = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
